// File: rtl/comparator_bist.sv
// Exhaustive self-test engine for a WIDTH-bit eq/gt magnitude comparator.
// Latency: SETTLE+1 cycles per vector, 2^(2*WIDTH)*(SETTLE+1) per run; start is ignored while busy.
// Backpressure: none; the comparator under test is sampled unconditionally in CHECK.
module comparator_bist #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic                 dut_eq,
    input  logic                 dut_gt,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     score,
    output logic [2*WIDTH:0]     fail_count,
    output logic [2*WIDTH+1:0]   first_fail
);
    localparam int VW = 2 * WIDTH;
    localparam int CW = VW + 1;

    typedef enum logic [1:0] {IDLE, SETTLE_WAIT, CHECK, DONE} state_t;

    state_t          state, state_nxt;
    logic [VW-1:0]   vec;
    logic [3:0]      settle_cnt;
    logic            exp_eq, exp_gt, mismatch, vec_last, launch;

    assign dut_a    = vec[VW-1:WIDTH];
    assign dut_b    = vec[WIDTH-1:0];
    assign exp_eq   = (dut_a == dut_b);
    assign exp_gt   = (dut_a > dut_b);
    // eq=gt=1 is never expected, so it falls out as a mismatch here.
    assign mismatch = (dut_eq != exp_eq) || (dut_gt != exp_gt);
    assign vec_last = &vec;
    assign launch   = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (start) state_nxt = SETTLE_WAIT;
            SETTLE_WAIT: if (settle_cnt == 4'd0) state_nxt = CHECK;
            CHECK:       state_nxt = vec_last ? DONE : SETTLE_WAIT;
            DONE:        if (start) state_nxt = SETTLE_WAIT;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            score      <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else if (launch) begin
            vec        <= '0;
            settle_cnt <= 4'(SETTLE - 1);
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            score      <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                SETTLE_WAIT: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_count <= fail_count + CW'(1);
                        if (!first_fail[VW+1]) first_fail <= {1'b1, dut_a, dut_b};
                    end else begin
                        score <= score + CW'(1);
                    end
                    if (vec_last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !mismatch && (fail_count == '0);
                    end else begin
                        vec        <= vec + VW'(1);
                        settle_cnt <= 4'(SETTLE - 1);
                    end
                end
                IDLE, DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: behavioural comparator models (ideal and faulty) beside three engine instances.
// Expected run results are queued at each start and popped when done rises.
module tb_comparator_bist;
    logic clk = 1'b0;
    logic rst_n, rst3_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // WIDTH=2, SETTLE=1 instance with selectable comparator fault
    logic       start2, eq2, gt2, busy2, done2, pass2;
    logic [1:0] a2, b2;
    logic [4:0] score2, fail2;
    logic [5:0] ff2;
    int         mode2 = 0;

    // WIDTH=2, SETTLE=3 instance, ideal comparator
    logic       start3, eq3, gt3, busy3, done3, pass3;
    logic [1:0] a3, b3;
    logic [4:0] score3, fail3;
    logic [5:0] ff3;

    // WIDTH=6, SETTLE=1 instance, ideal comparator
    logic        start6, eq6, gt6, busy6, done6, pass6;
    logic [5:0]  a6, b6;
    logic [12:0] score6, fail6;
    logic [13:0] ff6;

    function automatic logic [1:0] model(input logic [1:0] a, input logic [1:0] b, input int mode);
        logic e, g;
        e = (a == b);
        g = (a > b);
        if (mode == 1) g = 1'b0;
        if (mode == 2 && a == 2'd3 && b == 2'd3) begin
            e = 1'b1;
            g = 1'b1;
        end
        return {e, g};
    endfunction

    always_comb {eq2, gt2} = model(a2, b2, mode2);
    assign eq3 = (a3 == b3);
    assign gt3 = (a3 > b3);
    assign eq6 = (a6 == b6);
    assign gt6 = (a6 > b6);

    comparator_bist #(.WIDTH(2), .SETTLE(1)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(a2), .dut_b(b2),
        .dut_eq(eq2), .dut_gt(gt2), .busy(busy2), .done(done2), .pass(pass2),
        .score(score2), .fail_count(fail2), .first_fail(ff2));

    comparator_bist #(.WIDTH(2), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .dut_a(a3), .dut_b(b3),
        .dut_eq(eq3), .dut_gt(gt3), .busy(busy3), .done(done3), .pass(pass3),
        .score(score3), .fail_count(fail3), .first_fail(ff3));

    comparator_bist #(.WIDTH(6), .SETTLE(1)) u_w6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .dut_a(a6), .dut_b(b6),
        .dut_eq(eq6), .dut_gt(gt6), .busy(busy6), .done(done6), .pass(pass6),
        .score(score6), .fail_count(fail6), .first_fail(ff6));

    typedef struct {
        int         score;
        int         fails;
        logic       pass;
        logic [5:0] ff;
    } res_t;

    res_t sb2[$];

    function automatic res_t predict(input int mode);
        res_t r;
        logic [1:0] m, gold;
        r.score = 0;
        r.fails = 0;
        r.ff    = '0;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                m    = model(2'(a), 2'(b), mode);
                gold = {a == b, a > b};
                if (m == gold) r.score++;
                else begin
                    r.fails++;
                    if (!r.ff[5]) r.ff = {1'b1, 2'(a), 2'(b)};
                end
            end
        end
        r.pass = (r.fails == 0);
        return r;
    endfunction

    task automatic run2(input int mode, input string tag);
        int   cyc;
        res_t e;
        mode2 = mode;
        sb2.push_back(predict(mode));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check({tag, " done cleared"}, done2, 0);
        check({tag, " pass cleared"}, pass2, 0);
        check({tag, " score cleared"}, score2, 0);
        check({tag, " busy"}, busy2, 1);
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, 32);
        e = sb2.pop_front();
        check({tag, " score"}, score2, e.score);
        check({tag, " fail_count"}, fail2, e.fails);
        check({tag, " pass"}, pass2, e.pass);
        check({tag, " first_fail"}, ff2, e.ff);
        check({tag, " busy end"}, busy2, 0);
        check({tag, " sum"}, score2 + fail2, 16);
    endtask

    initial begin
        int cyc;
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        start6 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy2, 0);
        check("reset done", done2, 0);
        check("reset pass", pass2, 0);
        check("reset score", score2, 0);
        check("reset fail", fail2, 0);
        check("reset ff", ff2, 0);
        check("reset ops", {a2, b2}, 0);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        run2(0, "ideal");
        run2(1, "gt_stuck0");
        run2(2, "eq_gt_both");
        run2(0, "rerun");

        // Operand hold and mid-run start on the SETTLE=3 instance
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 300) begin
            if (cyc < 20) check("s3 hold", {a3, b3}, cyc / 4);
            start3 = (cyc == 10);
            @(negedge clk);
            cyc++;
        end
        start3 = 1'b0;
        check("s3 latency", cyc, 64);
        check("s3 score", score3, 16);
        check("s3 fail", fail3, 0);
        check("s3 pass", pass3, 1);

        // Reset abort during vector 5
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (21) @(negedge clk);
        check("s3 vec5", {a3, b3}, 5);
        check("s3 score mid", score3, 5);
        rst3_n = 1'b0;
        #1;
        check("abort busy", busy3, 0);
        check("abort score", score3, 0);
        check("abort ops", {a3, b3}, 0);
        check("abort done", done3, 0);
        @(negedge clk);
        rst3_n = 1'b1;

        // Wide exhaustive run
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        cyc = 0;
        while (done6 !== 1'b1 && cyc < 9000) begin
            @(negedge clk);
            cyc++;
        end
        check("w6 latency", cyc, 8192);
        check("w6 score", score6, 4096);
        check("w6 fail", fail6, 0);
        check("w6 pass", pass6, 1);
        check("w6 ff", ff6, 0);
        check("w6 last a", a6, 63);
        check("w6 last b", b6, 63);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
Synthesizable built-in self-test engine for the WIDTH-bit magnitude comparator (eq/gt outputs).
- Drives every operand pair (a, b) into the comparator under test, one pair at a time.
- Samples eq/gt after a programmable settle time and checks them against the golden relation.
- Accumulates pass/fail counts and captures the first failing vector.
- Sits beside the comparator as its stimulus/checker end, enabling on-chip exhaustive checking.

Parameters:
- WIDTH, 8, operand width of the comparator under test (legal 1..8).
- SETTLE, 1, cycles operands are held before eq/gt are sampled (legal 1..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- dut_a  out  WIDTH  operand A to the comparator
- dut_b  out  WIDTH  operand B to the comparator
- dut_eq  in  1  comparator equal output
- dut_gt  in  1  comparator greater-than output
- busy  out  1  high while a run is in progress
- done  out  1  high from run completion until the next accepted start
- pass  out  1  valid when done; 1 iff zero failures
- score  out  2*WIDTH+1  vectors passed in the current/last run
- fail_count  out  2*WIDTH+1  vectors failed in the current/last run
- first_fail  out  2*WIDTH+2  {valid, a, b} of the first failing vector

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE.
  - dut_a, dut_b, busy, done, pass, score, fail_count, first_fail all 0.
  - Internal vector counter vec (2*WIDTH bits) and settle counter cleared.
- Operand mapping: dut_a = vec[2*WIDTH-1:WIDTH], dut_b = vec[WIDTH-1:0]. Both are registered outputs driven directly from vec.
- FSM states: IDLE, SETTLE_WAIT, CHECK, DONE.
- IDLE:
  - start=1 -> clear vec, score, fail_count, first_fail, done, pass.
  - Load the settle counter with SETTLE-1.
  - busy=1; go to SETTLE_WAIT.
- SETTLE_WAIT:
  - Decrement the settle counter each cycle.
  - When it reaches 0, go to CHECK next cycle.
  - Operands are stable throughout.
- CHECK (exactly 1 cycle):
  - Sample dut_eq/dut_gt and compute the expected result with unsigned compare:
    - a>b -> eq=0, gt=1
    - a==b -> eq=1, gt=0
    - a<b -> eq=0, gt=0
  - eq=gt=1 is always a failure.
  - Match -> score+1. Mismatch -> fail_count+1.
  - On the first mismatch, first_fail={1, a, b}; it is never overwritten within the run.
  - vec all-ones -> go to DONE. Otherwise vec+1, reload the settle counter, go to SETTLE_WAIT.
- Per-vector latency: SETTLE+1 cycles. Run length: 2^(2*WIDTH)*(SETTLE+1) cycles from start to done.
- DONE:
  - busy=0, done=1, pass=(fail_count==0).
  - dut_a/dut_b hold the last vector.
  - start=1 -> behaves as start in IDLE; the new run begins next cycle.
- start while busy: ignored; no restart, counts unaffected.
- score+fail_count always equals vectors checked so far. Counter widths hold 2^(2*WIDTH) without overflow (65536 for WIDTH=8).
- Reset mid-run: immediate abort; all outputs return to reset values and no partial results are retained.

Test Plan:
- WIDTH=2, SETTLE=1, ideal comparator model, start pulse -> done after 32 cycles; score=16, fail_count=0, pass=1, first_fail valid=0.
- WIDTH=2, model with gt stuck-at-0 -> fail_count=6 (pairs with a>b), score=10, pass=0, first_fail={1,2'b01,2'b00}.
- WIDTH=2, model returning eq=gt=1 only for a=3,b=3 -> fail_count=1, first_fail={1,2'b11,2'b11}.
- WIDTH=8, SETTLE=1, ideal model -> done exactly 131072 cycles after start; score=65536, pass=1; dut_a/dut_b end at 8'hFF/8'hFF.
- WIDTH=2, SETTLE=3: dut_a/dut_b each hold for 4 cycles. start pulsed mid-run -> no restart, final score=16. rst_n low at vector 5 -> busy=0, score=0 immediately.
- After done, second start -> done and pass drop next cycle, counts cleared, full run repeats with identical results.
